nios_mult_pipe: RTL and testbench
=================================

Name: nios_mult_pipe

Overview:
- Parametrised pipelined integer multiplier for the Nios II-class CPU datapath.
- Successor to the fixed three-partial-product 16x16 multiply cell.
- Built from PART_W x PART_W partial products with a configurable number of stages.
- Supports the full MUL/MULXSS/MULXSU/MULXUU instruction set, per-op valid tracking, stall and flush.

Parameters:
- DATA_W, 32: operand and result width; must be 2*PART_W.
- PART_W, 16: partial-product width; maps onto one DSP multiplier.
- LATENCY, 2: enabled-clock cycles from issue to result; legal range 2..4.

Ports:
- clk  in  1  system clock; all registers rise-edge.
- reset_n  in  1  asynchronous active-low reset.
- E_src1  in  DATA_W  operand A.
- E_src2  in  DATA_W  operand B.
- E_mode  in  2  00 MUL (low word), 01 MULXSS, 10 MULXSU (A signed, B unsigned), 11 MULXUU; the three MULX modes return the high word.
- E_valid  in  1  issue qualifier, sampled when M_en=1.
- M_en  in  1  pipeline advance enable; when 0 every register, including valid, holds.
- flush  in  1  synchronous kill of all in-flight ops.
- M_result  out  DATA_W  selected word of the 2*DATA_W product.
- M_valid  out  1  M_result holds a completed op.
- busy  out  1  OR of all internal valid bits excluding the output stage.

Behaviour:
- Reset: every data and valid register is cleared to 0 asynchronously while reset_n=0. M_result=0, M_valid=0, busy=0.
- Reset mid-operation: in-flight ops are discarded and never appear on M_valid.
- Stage 1 (on enabled edge): register E_src1, E_src2, E_mode and E_valid.
  - Data registers load regardless of E_valid.
  - The valid bit loads E_valid & ~flush.
- Operand extension: each operand is extended to DATA_W+1 bits.
  - MSB is sign-extended if signed for the mode, else zero-extended.
  - MUL uses unsigned extension; the low word is identical for either signedness.
- Product formation:
  - Four PART_W x PART_W unsigned partial products: LL, LH, HL, HH.
  - Sign correction terms: subtract B<<DATA_W when A is negative and signed; subtract A<<DATA_W when B is negative and signed.
  - Summation is modulo 2^(2*DATA_W).
- Stage placement:
  - Partial products are registered at stage 2.
  - The final sum plus word select lands at stage LATENCY.
  - Any extra stages are placed before the final adder and implemented as retimable delay registers.
- Word select:
  - MUL: product[DATA_W-1:0].
  - Others: product[2*DATA_W-1:DATA_W].
- Latency: an op issued with E_valid=1 on enabled edge n appears with M_valid=1 after exactly LATENCY enabled edges. Disabled cycles do not count.
- Throughput: one op per enabled cycle; back-to-back issues produce back-to-back results.
- Stall (M_en=0): all outputs hold their values; flush is ignored.
- Flush (M_en=1, flush=1):
  - All valid bits, including M_valid, clear on that edge.
  - A simultaneous E_valid is also killed.
  - Data registers may update; their contents are don't-care.
- Empty pipeline: M_result retains the last computed value (it is not cleared) and M_valid=0.
- Invalid bubbles: data registers still advance, but M_valid stays 0; the bench checks M_result only when M_valid=1.
- Elaboration checks: DATA_W != 2*PART_W, or LATENCY outside 2..4, triggers $error.

Test Plan:
- All-ones operands: issue A=B=0xFFFFFFFF in each mode, LATENCY=2, M_en=1.
  - Required: M_valid high exactly 2 cycles after each issue.
  - Results: MUL 0x00000001, MULXUU 0xFFFFFFFE, MULXSS 0x00000000, MULXSU 0xFFFFFFFF.
- Mixed values: A=0x7FFFFFFF, B=0x80000000.
  - MULXSS gives 0xC0000000.
  - MULXUU gives 0x3FFFFFFF.
  - MUL gives 0x80000000.
- Stall: issue A=3, B=5 MUL, then hold M_en=0 for 4 cycles after the first edge.
  - Required: M_valid and M_result are unchanged during the stall.
  - 0x0000000F with M_valid=1 appears one enabled edge after M_en returns high.
- Flush: issue ops 1, 2, 3 back-to-back, then assert flush with M_en=1 while op 3 issues.
  - Required: none of the in-flight ops produces M_valid; busy=0 on the next cycle.
  - A subsequent op (2x2 MUL=4) completes normally.
- Reset mid-op: drop reset_n asynchronously between clock edges with two ops in flight.
  - Required: M_result=0, M_valid=0 and busy=0 immediately.
  - No stale valid after release.
- LATENCY=4 regression: run 1000 random back-to-back ops in random modes with random M_en gaps.
  - Required: a scoreboard matches every result in order.
  - No dropped or duplicated M_valid.

Source files
------------

// File: rtl/nios_mult_pipe.sv
// Pipelined DATA_W x DATA_W multiplier for MUL/MULXSS/MULXSU/MULXUU.
// Partial products at stage 2, optional delay stages, final sum at LATENCY.
module nios_mult_pipe #(
  parameter int DATA_W  = 32,
  parameter int PART_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic [1:0]        E_mode,
  input  logic              E_valid,
  input  logic              M_en,
  input  logic              flush,
  output logic [DATA_W-1:0] M_result,
  output logic              M_valid,
  output logic              busy
);

  localparam int PW2   = 2 * PART_W;
  localparam int PW    = 2 * DATA_W;
  localparam int DEPTH = (LATENCY > 2) ? LATENCY - 2 : 0;

  typedef struct packed {
    logic              v;
    logic              hi;
    logic [DATA_W-1:0] corr;
    logic [PW2-1:0]    ll;
    logic [PW2-1:0]    lh;
    logic [PW2-1:0]    hl;
    logic [PW2-1:0]    hh;
  } pp_t;

  generate
    if (DATA_W != 2 * PART_W) begin : g_chk_w
      $error("nios_mult_pipe: DATA_W must be 2*PART_W");
    end
    if (LATENCY < 2 || LATENCY > 4) begin : g_chk_l
      $error("nios_mult_pipe: LATENCY must be 2..4");
    end
  endgenerate

  function automatic logic [PW2-1:0] umul(
    input logic [PART_W-1:0] x,
    input logic [PART_W-1:0] y
  );
    return {{PART_W{1'b0}}, x} * {{PART_W{1'b0}}, y};
  endfunction

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [1:0]        mode_q, mode_d;
  logic              v1_q, v1_d;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    mode_d = mode_q;
    v1_d   = v1_q;
    if (M_en) begin
      a_d    = E_src1;
      b_d    = E_src2;
      mode_d = E_mode;
      v1_d   = E_valid & ~flush;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
      v1_q   <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      mode_q <= mode_d;
      v1_q   <= v1_d;
    end
  end

  logic              a_sgn, b_sgn;
  logic [DATA_W-1:0] corr_c;
  pp_t               pp_c;

  // Signed operands are handled as unsigned plus a high-word correction.
  always_comb begin
    a_sgn  = (mode_q == 2'b01) || (mode_q == 2'b10);
    b_sgn  = (mode_q == 2'b01);
    corr_c = '0;
    if (a_sgn && a_q[DATA_W-1]) corr_c = corr_c + b_q;
    if (b_sgn && b_q[DATA_W-1]) corr_c = corr_c + a_q;
    pp_c.v    = v1_q & ~flush;
    pp_c.hi   = |mode_q;
    pp_c.corr = corr_c;
    pp_c.ll   = umul(a_q[PART_W-1:0], b_q[PART_W-1:0]);
    pp_c.lh   = umul(a_q[PART_W-1:0], b_q[DATA_W-1:PART_W]);
    pp_c.hl   = umul(a_q[DATA_W-1:PART_W], b_q[PART_W-1:0]);
    pp_c.hh   = umul(a_q[DATA_W-1:PART_W], b_q[DATA_W-1:PART_W]);
  end

  pp_t  fin;
  logic dly_busy;

  generate
    if (DEPTH == 0) begin : g_nodly
      assign fin      = pp_c;
      assign dly_busy = 1'b0;
    end else begin : g_dly
      pp_t [DEPTH-1:0] pipe_q, pipe_d;

      always_comb begin
        pipe_d = pipe_q;
        if (M_en) begin
          pipe_d[0] = pp_c;
          for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i]   = pipe_q[i-1];
            pipe_d[i].v = pipe_q[i-1].v & ~flush;
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pipe_q <= '0;
        else          pipe_q <= pipe_d;
      end

      always_comb begin
        dly_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++)
          dly_busy = dly_busy | pipe_q[i].v;
      end

      assign fin = pipe_q[DEPTH-1];
    end
  endgenerate

  logic [PW-1:0]     prod;
  logic [DATA_W-1:0] res_q, res_d;
  logic              mv_q, mv_d;

  // Result register only loads completed ops so an empty pipe keeps it.
  always_comb begin
    prod  = PW'(fin.ll)
          + (PW'(fin.lh) << PART_W)
          + (PW'(fin.hl) << PART_W)
          + (PW'(fin.hh) << DATA_W)
          - (PW'(fin.corr) << DATA_W);
    res_d = res_q;
    mv_d  = mv_q;
    if (M_en) begin
      mv_d = fin.v & ~flush;
      if (fin.v)
        res_d = fin.hi ? prod[PW-1:DATA_W] : prod[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q <= '0;
      mv_q  <= 1'b0;
    end else begin
      res_q <= res_d;
      mv_q  <= mv_d;
    end
  end

  assign M_result = res_q;
  assign M_valid  = mv_q;
  assign busy     = v1_q | dly_busy;

endmodule

// File: tb/tb_nios_mult_pipe.sv
// Scoreboard bench for nios_mult_pipe, LATENCY=2 and LATENCY=4 side by side.
// Expected words come from a 64-bit reference multiply.
module tb_nios_mult_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [31:0] src1, src2;
  logic [1:0]  mode;
  logic        e_valid, m_en, flush;
  logic [31:0] res [2];
  logic        mv  [2];
  logic        bsy [2];

  nios_mult_pipe #(.LATENCY(2)) u_l2 (
    .clk(clk), .reset_n(reset_n),
    .E_src1(src1), .E_src2(src2), .E_mode(mode),
    .E_valid(e_valid), .M_en(m_en), .flush(flush),
    .M_result(res[0]), .M_valid(mv[0]), .busy(bsy[0])
  );

  nios_mult_pipe #(.LATENCY(4)) u_l4 (
    .clk(clk), .reset_n(reset_n),
    .E_src1(src1), .E_src2(src2), .E_mode(mode),
    .E_valid(e_valid), .M_en(m_en), .flush(flush),
    .M_result(res[1]), .M_valid(mv[1]), .busy(bsy[1])
  );

  typedef struct {
    logic [31:0] r;
    int          due;
  } exp_t;

  exp_t        sbq [2][$];
  int          checks = 0;
  int          errors = 0;
  int          en_cnt = 0;
  bit          last_en = 1'b0;
  bit          ovr = 1'b0;
  logic [31:0] ovr_val = '0;
  logic [31:0] prev_r [2];
  logic        prev_v [2];
  logic        prev_b [2];

  function automatic int lat(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_mul(
    input logic [31:0] a, input logic [31:0] b, input logic [1:0] m
  );
    logic [63:0] ax, bx, p;
    bit sa, sb;
    sa = (m == 2'd1) || (m == 2'd2);
    sb = (m == 2'd1);
    ax = sa ? {{32{a[31]}}, a} : {32'b0, a};
    bx = sb ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ax * bx;
    return (m == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string nm, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[L%0d] t=%0t: got %h, expected %h",
               nm, lat(d), $time, act, exp);
    end
  endtask

  // Reference model: every enabled edge is one step of the pipeline.
  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      last_en = 1'b0;
    end else begin
      last_en = m_en;
      if (m_en) begin
        en_cnt++;
        for (int i = 0; i < 2; i++) begin
          if (flush)
            sbq[i].delete();
          else if (e_valid)
            sbq[i].push_back('{ovr ? ovr_val : ref_mul(src1, src2, mode),
                               en_cnt + lat(i) - 1});
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset_n) begin
        if (last_en) begin
          if (mv[i]) begin
            if (sbq[i].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_valid[L%0d] t=%0t: got result %h, expected no op",
                       lat(i), $time, res[i]);
            end else begin
              exp_t e;
              e = sbq[i].pop_front();
              check("result", i, res[i], e.r);
              check("latency_edge", i, en_cnt, e.due);
            end
          end else if (sbq[i].size() > 0 && sbq[i][0].due <= en_cnt) begin
            checks++;
            errors++;
            $display("FAIL missing_valid[L%0d] t=%0t: got M_valid=0, expected %h",
                     lat(i), $time, sbq[i][0].r);
            void'(sbq[i].pop_front());
          end
        end else begin
          check("stall_result", i, res[i], prev_r[i]);
          check("stall_valid", i, 32'(mv[i]), 32'(prev_v[i]));
          check("stall_busy", i, 32'(bsy[i]), 32'(prev_b[i]));
        end
      end
      prev_r[i] = res[i];
      prev_v[i] = mv[i];
      prev_b[i] = bsy[i];
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] m, input logic v, input logic en,
                       input logic fl, input bit o = 1'b0,
                       input logic [31:0] ov = '0);
    @(negedge clk);
    src1    = a;
    src2    = b;
    mode    = m;
    e_valid = v;
    m_en    = en;
    flush   = fl;
    ovr     = o;
    ovr_val = ov;
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, '0, 2'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_zero(input string nm);
    for (int i = 0; i < 2; i++) begin
      check({nm, "_result"}, i, res[i], 32'h0);
      check({nm, "_valid"}, i, 32'(mv[i]), 32'h0);
      check({nm, "_busy"}, i, 32'(bsy[i]), 32'h0);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic en, v, fl;
    reset_n = 1'b0;
    src1 = '0; src2 = '0; mode = '0;
    e_valid = 1'b0; m_en = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    #2 reset_n = 1'b1;

    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 1, 1, 0, 1, 32'h0000_0001);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 1, 1, 0, 1, 32'hFFFF_FFFE);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd1, 1, 1, 0, 1, 32'h0000_0000);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 1, 1, 0, 1, 32'hFFFF_FFFF);
    drive(32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 1, 1, 0, 1, 32'hC000_0000);
    drive(32'h7FFF_FFFF, 32'h8000_0000, 2'd3, 1, 1, 0, 1, 32'h3FFF_FFFF);
    drive(32'h7FFF_FFFF, 32'h8000_0000, 2'd0, 1, 1, 0, 1, 32'h8000_0000);
    idle(6);

    drive(32'd3, 32'd5, 2'd0, 1, 1, 0, 1, 32'h0000_000F);
    repeat (4) drive('0, '0, 2'd0, 0, 0, 0);
    idle(6);

    drive(32'd1, 32'd1, 2'd0, 1, 1, 0);
    drive(32'd2, 32'd2, 2'd0, 1, 1, 0);
    drive(32'd3, 32'd3, 2'd0, 1, 1, 1);
    drive(32'd2, 32'd2, 2'd0, 1, 1, 0, 1, 32'h0000_0004);
    for (int i = 0; i < 2; i++)
      check("flush_busy", i, 32'(bsy[i]), 32'h0);
    idle(6);

    drive(32'd6, 32'd7, 2'd0, 1, 1, 0);
    drive(32'd8, 32'd9, 2'd1, 1, 1, 0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    e_valid = 1'b0;
    for (int i = 0; i < 2; i++) sbq[i].delete();
    #1 check_zero("midop_reset");
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    idle(6);

    n = 0;
    while (n < 1000) begin
      en = ($urandom_range(0, 3) != 0);
      v  = ($urandom_range(0, 7) != 0);
      fl = !en && ($urandom_range(0, 3) == 0);
      drive(rnd_op(), rnd_op(), 2'($urandom_range(0, 3)), v, en, fl);
      if (en && v) n++;
    end
    idle(10);

    for (int i = 0; i < 2; i++)
      check("drained", i, 32'(sbq[i].size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t: got no finish, expected end of run", $time);
    $fatal(1, "timeout");
  end

endmodule
